// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: state encodings, stream byte width and memory-depth helper shared by the loader.
// Revision 1.0
`default_nettype none

package imem_loader_pkg;

  localparam int BYTE_W = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LEN_HI  = 3'd1;
  localparam logic [2:0] ST_LEN_LO  = 3'd2;
  localparam logic [2:0] ST_DATA_HI = 3'd3;
  localparam logic [2:0] ST_DATA_LO = 3'd4;
  localparam logic [2:0] ST_CHECK   = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;
  localparam logic [2:0] ST_ERROR   = 3'd7;

  function automatic int imem_depth(input int width);
    return 1 << width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader.sv
// imem_loader: framed byte stream -> big-endian 16-bit instruction-memory writes, CPU held in reset until loaded.
// Revision 1.0
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BYTE_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [WIDTH-1:0]      imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  localparam logic [16:0]    MAX_LEN  = 17'(imem_depth(WIDTH));
  localparam logic [WIDTH:0] REM_ONE  = 1;
  localparam logic [WIDTH-1:0] ADDR_ONE = 1;

  logic [2:0]        r_state;
  logic [2:0]        w_state_next;
  logic [BYTE_W-1:0] r_sum;
  logic [BYTE_W-1:0] r_len_hi;
  logic [BYTE_W-1:0] r_hi_byte;
  logic [WIDTH:0]    r_remaining;
  logic [WIDTH-1:0]  r_addr_cnt;
  logic              w_xfer;
  logic              w_idle_like;
  logic [16:0]       w_len;

  assign w_xfer      = in_valid & in_ready;
  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR);
  assign w_len       = {1'b0, r_len_hi, in_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) w_state_next = ST_LEN_HI;
      ST_LEN_HI:  if (w_xfer) w_state_next = ST_LEN_LO;
      ST_LEN_LO: begin
        if (w_xfer) begin
          if (w_len == 17'd0)      w_state_next = ST_CHECK;
          else if (w_len > MAX_LEN) w_state_next = ST_ERROR;
          else                      w_state_next = ST_DATA_HI;
        end
      end
      ST_DATA_HI: if (w_xfer) w_state_next = ST_DATA_LO;
      ST_DATA_LO: begin
        if (w_xfer) w_state_next = (r_remaining == REM_ONE) ? ST_CHECK : ST_DATA_HI;
      end
      ST_CHECK: begin
        if (w_xfer) w_state_next = (in_data == r_sum) ? ST_DONE : ST_ERROR;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // All status outputs decode the registered state, so they change the cycle after the deciding transfer.
  always_comb begin
    in_ready  = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_reset = 1'b1;
    case (r_state)
      ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CHECK: in_ready = 1'b1;
      ST_DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
      end
      ST_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum       <= '0;
      r_len_hi    <= '0;
      r_hi_byte   <= '0;
      r_remaining <= '0;
      r_addr_cnt  <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
    end else begin
      imem_we <= 1'b0;
      if (start && w_idle_like) begin
        r_sum       <= '0;
        r_remaining <= '0;
        r_addr_cnt  <= '0;
      end
      if (w_xfer) begin
        case (r_state)
          ST_LEN_HI: begin
            r_len_hi <= in_data;
            r_sum    <= r_sum + in_data;
          end
          ST_LEN_LO: begin
            r_remaining <= w_len[WIDTH:0];
            r_sum       <= r_sum + in_data;
          end
          ST_DATA_HI: begin
            r_hi_byte <= in_data;
            r_sum     <= r_sum + in_data;
          end
          ST_DATA_LO: begin
            imem_we     <= 1'b1;
            imem_addr   <= r_addr_cnt;
            imem_wdata  <= {r_hi_byte, in_data};
            r_addr_cnt  <= r_addr_cnt + ADDR_ONE;
            r_remaining <= r_remaining - REM_ONE;
            r_sum       <= r_sum + in_data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames with a write scoreboard drained by an independent monitor.
// Revision 1.0
`default_nettype none

module tb_imem_loader;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;

  imem_loader #(.WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [7:0]       frame_q[$];
  bit               use_gaps = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {4'h0, imem_addr, imem_wdata}, 32'hFFFF_FFFF);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(e[AW+DW-1:DW]));
        check("write_data", 32'(imem_wdata), 32'(e[DW-1:0]));
        check("cpu_reset_during_write", 32'(cpu_reset), 32'd1);
      end
    end
  end

  task automatic push_exp(input int addr, input logic [15:0] data);
    exp_q.push_back({addr[AW-1:0], data});
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waitc;
    int gap;
    gap = use_gaps ? int'($urandom_range(0, 2)) : 0;
    for (int k = 0; k < gap; k++) begin
      in_valid = 1'b0;
      start    = (k == 0);
      @(negedge clk);
      start    = 1'b0;
    end
    in_valid = 1'b1;
    in_data  = b;
    waitc    = 0;
    while (!in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame();
    while (frame_q.size() != 0) send_byte(frame_q.pop_front());
  endtask

  task automatic load_frame_a(input logic [7:0] chk);
    frame_q = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, chk};
    push_exp(0, 16'h1234);
    push_exp(1, 16'hABCD);
    push_exp(2, 16'h0001);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic cr);
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_error"}, 32'(error), 32'(e));
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(cr));
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  s;
    logic [15:0] w;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);

    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", 32'(imem_wdata), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Good three-word frame at full rate.
    do_start();
    check("start_in_ready", 32'(in_ready), 32'd1);
    load_frame_a(8'hC2);
    send_frame();
    check_status("frame_a", 1'b1, 1'b0, 1'b0);

    // Same frame, bad checksum, restarted from DONE.
    do_start();
    check("restart_done_cleared", 32'(done), 32'd0);
    check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    load_frame_a(8'hC3);
    send_frame();
    check_status("bad_chk", 1'b0, 1'b1, 1'b1);

    // Empty frame, restarted from ERROR.
    do_start();
    frame_q = '{8'h00, 8'h00, 8'h00};
    send_frame();
    check_status("empty", 1'b1, 1'b0, 1'b0);

    // Length 0x1001 exceeds a 4096-word memory.
    do_start();
    frame_q = '{8'h10, 8'h01};
    send_frame();
    check_status("len_reject", 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check("len_reject_hold", 32'(error), 32'd1);

    // Gapped stream with ignored mid-frame start pulses.
    do_start();
    use_gaps = 1'b1;
    load_frame_a(8'hC2);
    send_frame();
    use_gaps = 1'b0;
    check_status("gapped", 1'b1, 1'b0, 1'b0);

    // Full memory: 4096 words, last address 0xFFF.
    do_start();
    frame_q = '{8'h10, 8'h00};
    s = 8'h10;
    for (int i = 0; i < 4096; i++) begin
      w = 16'(i * 16'h0101 + 16'h5A3C);
      frame_q.push_back(w[15:8]);
      frame_q.push_back(w[7:0]);
      s = s + w[15:8] + w[7:0];
      push_exp(i, w);
    end
    frame_q.push_back(s);
    send_frame();
    check_status("full_mem", 1'b1, 1'b0, 1'b0);
    check("full_mem_last_addr", 32'(imem_addr), 32'h0FFF);

    // Reset after four bytes, then a clean reload from address 0.
    do_start();
    frame_q = '{8'h00, 8'h03, 8'h12, 8'h34};
    push_exp(0, 16'h1234);
    send_frame();
    reset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_imem_addr", 32'(imem_addr), 32'd0);
    check("midrst_imem_wdata", 32'(imem_wdata), 32'd0);
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    check("midrst_pending", 32'(exp_q.size()), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    do_start();
    load_frame_a(8'hC2);
    send_frame();
    check_status("reload", 1'b1, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
